// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, the hard-wired zero register
// and the ID/EX register layout.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic [CTRL_W-1:0] ctrl;
    } ex_bundle_t;

endpackage

// File: rtl/operand_bypass.sv
// Single-source operand select: x0, then the EX result, then the MEM result,
// then the register file value.
module operand_bypass
    import pipe_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [4:0]       src_i,
    input  logic [WIDTH-1:0] rf_data_i,
    input  logic             ex_hit_en_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [WIDTH-1:0] ex_data_i,
    input  logic             mem_hit_en_i,
    input  logic [4:0]       mem_rd_i,
    input  logic [WIDTH-1:0] mem_data_i,
    output logic [WIDTH-1:0] operand_o
);

    always_comb begin
        operand_o = rf_data_i;
        if (src_i == REG_ZERO) begin
            operand_o = '0;
        end else if (ex_hit_en_i && (ex_rd_i == src_i)) begin
            operand_o = ex_data_i;
        end else if (mem_hit_en_i && (mem_rd_i == src_i)) begin
            operand_o = mem_data_i;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: regfile addressing, EX/MEM bypass, load-use stall and the
// ID/EX pipeline register with a saturating bubble counter.
module operand_fetch_stage #(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [4:0]        R1Num,
    output logic [4:0]        R2Num,
    input  logic [XLEN-1:0]   A,
    input  logic [XLEN-1:0]   B,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [4:0]        mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_pkg::ex_bundle_t ex_q, ex_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]      op_a, op_b;
    logic                 ex_fwd_en;
    logic                 load_use;

    assign R1Num = id_rs1;
    assign R2Num = id_rs2;

    // A load's EX-stage result is an address, so loads never forward from EX.
    assign ex_fwd_en = ex_q.valid & ex_q.reg_write & ~ex_q.mem_read;

    operand_bypass #(.WIDTH(XLEN)) u_bypass_a (
        .src_i        (id_rs1),
        .rf_data_i    (A),
        .ex_hit_en_i  (ex_fwd_en),
        .ex_rd_i      (ex_q.rd),
        .ex_data_i    (ex_result),
        .mem_hit_en_i (mem_reg_write),
        .mem_rd_i     (mem_rd),
        .mem_data_i   (mem_result),
        .operand_o    (op_a)
    );

    operand_bypass #(.WIDTH(XLEN)) u_bypass_b (
        .src_i        (id_rs2),
        .rf_data_i    (B),
        .ex_hit_en_i  (ex_fwd_en),
        .ex_rd_i      (ex_q.rd),
        .ex_data_i    (ex_result),
        .mem_hit_en_i (mem_reg_write),
        .mem_rd_i     (mem_rd),
        .mem_data_i   (mem_result),
        .operand_o    (op_b)
    );

    assign load_use = id_valid & ex_q.valid & ex_q.mem_read
                    & (ex_q.rd != pipe_pkg::REG_ZERO)
                    & ((id_use_rs1 & (id_rs1 == ex_q.rd))
                     | (id_use_rs2 & (id_rs2 == ex_q.rd)));

    assign id_stall = ex_hold | (load_use & ~flush);

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (ex_hold) begin
            ex_d = ex_q;
        end else if (flush || load_use) begin
            // Bubble: data fields are left as-is, only the qualifiers drop.
            ex_d.valid     = 1'b0;
            ex_d.reg_write = 1'b0;
            ex_d.mem_read  = 1'b0;
            ex_d.ctrl      = '0;
            if (!flush && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            ex_d.valid     = id_valid;
            ex_d.pc        = id_pc;
            ex_d.a         = op_a;
            ex_d.b         = op_b;
            ex_d.imm       = id_imm;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write & id_valid;
            ex_d.mem_read  = id_mem_read & id_valid;
            ex_d.ctrl      = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_a         = ex_q.a;
    assign ex_b         = ex_q.b;
    assign ex_imm       = ex_q.imm;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_ctrl      = ex_q.ctrl;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios with literal expectations
// plus a per-cycle comparison against a behavioural model of the stage.
module tb_operand_fetch_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1, id_rs2;
    logic              id_use_rs1, id_use_rs2;
    logic [4:0]        id_rd;
    logic              id_reg_write, id_mem_read;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        R1Num, R2Num;
    logic [XLEN-1:0]   A, B;
    logic [XLEN-1:0]   ex_result;
    logic [4:0]        mem_rd;
    logic              mem_reg_write;
    logic [XLEN-1:0]   mem_result;
    logic              ex_hold, flush;
    logic              id_stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]        ex_rd;
    logic              ex_reg_write, ex_mem_read;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    operand_fetch_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .R1Num(R1Num), .R2Num(R2Num), .A(A), .B(B),
        .ex_result(ex_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_result(mem_result), .ex_hold(ex_hold), .flush(flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model of the instruction sitting in EX, kept as plain variables.
    logic              m_valid, m_rw, m_mr;
    logic [XLEN-1:0]   m_pc, m_a, m_b, m_imm;
    logic [4:0]        m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_cnt;

    function automatic logic [XLEN-1:0] exp_op(input logic [4:0] s, input logic [XLEN-1:0] rf);
        if (s == 5'd0) return '0;
        if (m_valid && m_rw && !m_mr && m_rd == s) return ex_result;
        if (mem_reg_write && mem_rd == s) return mem_result;
        return rf;
    endfunction

    function automatic logic exp_lu();
        return id_valid && m_valid && m_mr && (m_rd != 5'd0) &&
               ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_pc = 0; m_a = 0; m_b = 0;
            m_imm = 0; m_rd = 0; m_ctrl = 0; m_cnt = 0;
        end else if (ex_hold) begin
            m_cnt = m_cnt;
        end else if (flush || exp_lu()) begin
            if (!flush && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            m_valid = 0; m_rw = 0; m_mr = 0; m_ctrl = 0;
        end else begin
            logic [XLEN-1:0] na, nb;
            na = exp_op(id_rs1, A);
            nb = exp_op(id_rs2, B);
            m_valid = id_valid;
            m_pc    = id_pc;
            m_a     = na;
            m_b     = nb;
            m_imm   = id_imm;
            m_rd    = id_rd;
            m_rw    = id_valid & id_reg_write;
            m_mr    = id_valid & id_mem_read;
            m_ctrl  = id_valid ? id_ctrl : '0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_id_stall", id_stall, ex_hold | (exp_lu() & ~flush));
            chk("m_r1num", R1Num, id_rs1);
            chk("m_ex_valid", ex_valid, m_valid);
            chk("m_ex_reg_write", ex_reg_write, m_rw);
            chk("m_ex_mem_read", ex_mem_read, m_mr);
            chk("m_ex_ctrl", ex_ctrl, m_ctrl);
            chk("m_stall_cnt", stall_cnt, m_cnt);
            if (m_valid) begin
                chk("m_ex_pc", ex_pc, m_pc);
                chk("m_ex_a", ex_a, m_a);
                chk("m_ex_b", ex_b, m_b);
                chk("m_ex_imm", ex_imm, m_imm);
                chk("m_ex_rd", ex_rd, m_rd);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) assert (!(flush && ex_hold)) else $error("FAIL flush_hold_overlap");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; id_imm = 0; id_ctrl = 0;
        A = 0; B = 0; ex_result = 0; mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        ex_hold = 0; flush = 0;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic [31:0] imm, input logic [7:0] ctrl);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_imm = imm; id_ctrl = ctrl;
    endtask

    initial begin
        idle();
        #12;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        rst = 0;
        tick();

        // EX bypass: add x5 then add x6,x5,x1 with stale A
        idle();
        set_id(1, 'h100, 1, 2, 1, 1, 5, 1, 0, 'h0, 'h01); A = 'h11; B = 'h22;
        tick();
        chk("exb_first_a", ex_a, 'h11);
        set_id(1, 'h104, 5, 1, 1, 1, 6, 1, 0, 'h0, 'h01); A = 'hDEAD; B = 'h11; ex_result = 'h1234;
        tick();
        chk("exb_ex_a", ex_a, 'h1234);
        chk("exb_ex_b", ex_b, 'h11);

        // MEM vs EX priority on x7
        idle();
        set_id(1, 'h200, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        tick();
        set_id(1, 'h204, 7, 0, 1, 0, 8, 1, 0, 0, 0); A = 'h55;
        mem_reg_write = 1; mem_rd = 7; mem_result = 'hAA; ex_result = 'hBB;
        tick();
        chk("prio_ex_wins", ex_a, 'hBB);
        set_id(1, 'h208, 7, 0, 1, 0, 9, 0, 0, 0, 0);
        tick();
        chk("prio_mem", ex_a, 'hAA);

        // Load-use: lw x3 then add x4,x3,x3
        idle();
        set_id(1, 'h300, 0, 0, 0, 0, 3, 1, 1, 4, 0);
        tick();
        set_id(1, 'h304, 3, 3, 1, 1, 4, 1, 0, 0, 0); A = 1; B = 2;
        #1;
        chk("lu_stall", id_stall, 1);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_cnt", stall_cnt, 1);
        chk("lu_stall_clear", id_stall, 0);
        mem_reg_write = 1; mem_rd = 3; mem_result = 'h777;
        tick();
        chk("lu_a", ex_a, 'h777);
        chk("lu_b", ex_b, 'h777);
        chk("lu_valid", ex_valid, 1);

        // x0 is never forwarded and never stalls
        idle();
        set_id(1, 'h400, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        set_id(1, 'h404, 0, 0, 1, 0, 10, 1, 0, 0, 0); ex_result = 'hFFFF; A = 'h99;
        #1;
        chk("x0_nostall", id_stall, 0);
        tick();
        chk("x0_ex_a", ex_a, 0);
        idle();
        set_id(1, 'h408, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        set_id(1, 'h40c, 0, 0, 1, 1, 11, 1, 0, 0, 0);
        #1;
        chk("x0_load_nostall", id_stall, 0);
        tick();

        // Hold for 3 cycles
        idle();
        set_id(1, 'h500, 1, 2, 1, 1, 12, 1, 0, 'h5, 'h3C); A = 'h10; B = 'h20;
        tick();
        chk("hold_pre_pc", ex_pc, 'h500);
        set_id(1, 'h504, 1, 2, 1, 1, 13, 1, 0, 'h6, 'h11);
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_stall", id_stall, 1);
            tick();
            chk("hold_pc", ex_pc, 'h500);
            chk("hold_ctrl", ex_ctrl, 'h3C);
        end
        ex_hold = 0;
        tick();
        chk("hold_release_pc", ex_pc, 'h504);

        // Flush alone, then flush masking a load-use
        idle();
        set_id(1, 'h600, 0, 0, 0, 0, 13, 1, 0, 0, 'h7); flush = 1;
        tick();
        chk("flush_valid", ex_valid, 0);
        chk("flush_ctrl", ex_ctrl, 0);
        idle();
        set_id(1, 'h610, 0, 0, 0, 0, 14, 1, 1, 0, 0);
        tick();
        set_id(1, 'h614, 14, 0, 1, 0, 15, 1, 0, 0, 0); flush = 1;
        #1;
        chk("flush_mask_stall", id_stall, 0);
        tick();
        chk("flush_cnt_same", stall_cnt, 1);

        // Counter saturation (width 2)
        for (int i = 0; i < 3; i++) begin
            idle();
            set_id(1, 'h700, 0, 0, 0, 0, 16, 1, 1, 0, 0);
            tick();
            set_id(1, 'h704, 0, 16, 0, 1, 17, 1, 0, 0, 0);
            tick();
            if (i == 0) chk("sat_cnt_2", stall_cnt, 2);
        end
        chk("sat_cnt_3", stall_cnt, 3);

        // Mixed traffic checked by the model only
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            set_id($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom);
            A = $urandom; B = $urandom; ex_result = $urandom; mem_result = $urandom;
            mem_rd = $urandom_range(0, 7); mem_reg_write = $urandom_range(0, 1);
            ex_hold = (r == 0);
            flush = (r == 1);
            tick();
        end

        // Asynchronous reset mid-run
        idle();
        set_id(1, 'h800, 0, 0, 0, 0, 5, 1, 0, 0, 'hFF);
        tick();
        #2;
        rst = 1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_pc", ex_pc, 0);
        chk("arst_ctrl", ex_ctrl, 0);
        chk("arst_rw", ex_reg_write, 0);
        chk("arst_cnt", stall_cnt, 0);
        #2;
        rst = 0;
        idle();
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
